uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- 8N1 UART receiver that sits directly upstream of the command decoder.
- Oversamples the serial line, reassembles bytes LSB-first and presents each one on a held byte register `rec_data`, plus a one-cycle `data_valid` strobe.
- `rec_data` holds the last byte until the consumer clears it, so a slower command decoder can sample it at any time.
- Framing errors and overruns are flagged, never silently delivered.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, samples per bit. Must be even and ≥ 8.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) truncated (default 651), clocks per sample tick. Derived localparam, not overridable.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RX  in  1  asynchronous serial input, idle high.
- rec_clr  in  1  one-cycle pulse; consumer has taken `rec_data`.
- rec_data  out  8  last good byte; 8'h00 = nothing pending.
- data_valid  out  1  one-cycle pulse when `rec_data` is loaded.
- frame_err  out  1  one-cycle pulse on bad stop bit.
- overrun  out  1  sticky; a new byte overwrote an uncleared nonzero `rec_data`.
- rx_busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Outputs: rec_data=8'h00, data_valid=0, frame_err=0, overrun=0, rx_busy=0.
  - Internals: FSM=IDLE, both synchronizer flops=1, tick and bit counters=0.
  - Reset asserted mid-frame aborts the frame; no partial byte is delivered.
- Input synchronizer:
  - RX passes through 2 flops (rx_s); all logic uses rx_s.
  - Total input latency is 2 cycles.
- Tick generator:
  - Counter 0..TICK_DIV-1 produces a 1-cycle `tick` on the wrap.
  - Counter is forced to 0 on the IDLE→START transition, so sample phase aligns to the detected edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s=0 → START, sample count cleared.
  - START: at tick count OVERSAMPLE/2 (mid start bit):
    - rx_s=0 → DATA, sample count=0, bit index=0.
    - rx_s=1 → IDLE (glitch rejected, no flag).
  - DATA: every OVERSAMPLE ticks, shift rx_s into bit[index], LSB first. After bit index 7 → STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit):
    - rx_s=1 → load rec_data with the shifted byte, pulse data_valid, → IDLE.
    - rx_s=0 → pulse frame_err, rec_data unchanged, → BREAK.
  - BREAK: wait until rx_s=1, then → IDLE. Held-low break produces exactly one frame_err.
- Latency: data_valid asserts 2 + TICK_DIV*(OVERSAMPLE*9 + OVERSAMPLE/2) ±1 cycles after the RX falling edge.
- rec_clr:
  - Sets rec_data=8'h00 and overrun=0 on the next edge.
  - If it coincides with a byte load, the load wins (rec_data=new byte) and overrun is cleared.
- overrun:
  - Set on a byte load when rec_data≠0 and no rec_clr is given in the same cycle.
  - The new byte still overwrites rec_data.
- A received byte 8'h00 loads rec_data=0 and pulses data_valid. Consumers that use "nonzero = pending" will not see it; accepted.
- rx_busy = (state≠IDLE), registered.
- Back-to-back frames: a falling edge seen in IDLE immediately after STOP is accepted. There is no dead time beyond the half stop bit.

Test Plan (sim with CLK_FREQ=1600000, BAUD=10000 → TICK_DIV=10, 160 clk/bit):
- Reset check: drive RESET=0 mid-frame, then release → all outputs at reset values; next valid frame 0x53 received correctly.
- Command sequence: send "S","T","A","R","T" (0x53 0x54 0x41 0x52 0x54) back-to-back, rec_clr after each data_valid → five data_valid pulses with matching rec_data, overrun=0. Latency from falling edge within 1522±1 clk.
- Glitch rejection: RX low for 40 clk, then high → stays IDLE; no data_valid, no frame_err; rx_busy returns to 0 within 82 clk.
- Framing error: send 0x4F with stop bit=0, RX held low for 2 bit times → exactly one frame_err pulse, rec_data unchanged. After RX high, next frame 0x50 → rec_data=0x50.
- Overrun: send 0x53 then 0x4F with no rec_clr → overrun=1, rec_data=0x4F. Then pulse rec_clr → rec_data=0x00, overrun=0.
- Simultaneous: pulse rec_clr on the same cycle as the 0x54 load → rec_data=0x54, overrun=0.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversampled start/data/stop detection, LSB-first byte
// assembly, and a held output register with framing-error and overrun flags.
module uart_rx_byte #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    input  logic       rec_clr,
    output logic [7:0] rec_data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [TW-1:0] r_tick_cnt;
    logic [SW-1:0] r_samp_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    state_t        r_state;
    logic [7:0]    r_rec_data;
    logic          r_data_valid;
    logic          r_frame_err;
    logic          r_overrun;
    logic          r_rx_busy;

    state_t        w_state_next;
    logic [SW-1:0] w_samp_next;
    logic [2:0]    w_bit_next;
    logic [7:0]    w_shift_next;
    logic          w_load;
    logic          w_ferr;
    logic          w_tick;
    logic          w_edge_start;

    assign w_tick       = (r_tick_cnt == TICK_LAST);
    assign w_edge_start = (r_state == IDLE) && !r_rx_s;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Sample-tick divider, re-phased to the detected start edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tick_cnt <= '0;
        end else if (w_edge_start || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_samp_next  = r_samp_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = START;
                    w_samp_next  = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_samp_cnt == SAMP_HALF) begin
                        w_samp_next  = '0;
                        w_bit_next   = 3'd0;
                        w_state_next = r_rx_s ? IDLE : DATA;
                    end else begin
                        w_samp_next = r_samp_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_samp_cnt == SAMP_LAST) begin
                        w_samp_next  = '0;
                        w_shift_next = {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            w_state_next = STOP;
                        end else begin
                            w_bit_next = r_bit_idx + 3'd1;
                        end
                    end else begin
                        w_samp_next = r_samp_cnt + SW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_samp_cnt == SAMP_LAST) begin
                        w_samp_next = '0;
                        if (r_rx_s) begin
                            w_load       = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_ferr       = 1'b1;
                            w_state_next = BREAK;
                        end
                    end else begin
                        w_samp_next = r_samp_cnt + SW'(1);
                    end
                end
            end
            BREAK: begin
                if (r_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_samp_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_rx_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_samp_cnt <= w_samp_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_rx_busy  <= (w_state_next != IDLE);
        end
    end

    // A load coinciding with rec_clr delivers the new byte and counts as consumed
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rec_data   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_data_valid <= w_load;
            r_frame_err  <= w_ferr;
            if (w_load) begin
                r_rec_data <= w_shift_next;
                if (rec_clr) begin
                    r_overrun <= 1'b0;
                end else if (r_rec_data != 8'h00) begin
                    r_overrun <= 1'b1;
                end
            end else if (rec_clr) begin
                r_rec_data <= 8'h00;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign rec_data   = r_rec_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign rx_busy    = r_rx_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 160 clocks per bit (TICK_DIV = 10).
module tb_uart_rx_byte;

    localparam int BIT_CLK = 160;

    logic       CLK;
    logic       RESET;
    logic       RX;
    logic       rec_clr;
    logic [7:0] rec_data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    logic clr_manual;
    logic clr_auto;
    logic auto_en;
    assign rec_clr = clr_manual | clr_auto;

    int n_cmp;
    int n_err;
    int cycle;
    int t_fall;
    int dv_cnt;
    int fe_cnt;
    int last_lat;
    logic [7:0] last_byte;
    logic [7:0] cmd [5] = '{8'h53, 8'h54, 8'h41, 8'h52, 8'h54};

    uart_rx_byte #(
        .CLK_FREQ  (1600000),
        .BAUD      (10000),
        .OVERSAMPLE(16)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RX        (RX),
        .rec_clr   (rec_clr),
        .rec_data  (rec_data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cycle = 0;
    always @(posedge CLK) cycle = cycle + 1;

    // Observer: counts strobes, logs each delivered byte, auto-acknowledges when enabled
    initial begin
        dv_cnt   = 0;
        fe_cnt   = 0;
        last_lat = 0;
        last_byte = 8'h00;
        clr_auto = 1'b0;
        forever begin
            @(negedge CLK);
            clr_auto = 1'b0;
            if (data_valid === 1'b1) begin
                dv_cnt    = dv_cnt + 1;
                last_byte = rec_data;
                last_lat  = cycle - t_fall;
                clr_auto  = auto_en;
                $display("rx byte 0x%02h latency %0d overrun %0b", rec_data, last_lat, overrun);
            end
            if (frame_err === 1'b1) begin
                fe_cnt = fe_cnt + 1;
                $display("frame error, rec_data 0x%02h", rec_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        @(negedge CLK);
        RX = 1'b0;
        t_fall = cycle;
        repeat (BIT_CLK) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BIT_CLK) @(negedge CLK);
        end
        RX = stop_val;
        repeat (BIT_CLK - 1) @(negedge CLK);
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        clr_manual = 1'b1;
        @(negedge CLK);
        clr_manual = 1'b0;
    endtask

    initial begin
        int dv0;
        int fe0;
        int rise;
        int fall;
        n_cmp      = 0;
        n_err      = 0;
        t_fall     = 0;
        RESET      = 1'b0;
        RX         = 1'b1;
        clr_manual = 1'b0;
        auto_en    = 1'b0;

        repeat (3) @(negedge CLK);
        chk("reset rec_data", 32'(rec_data), 32'h00);
        chk("reset data_valid", 32'(data_valid), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        chk("reset rx_busy", 32'(rx_busy), 32'h0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        send_frame(8'h53, 1'b1);
        chk("first byte", 32'(rec_data), 32'h53);
        chk("first dv count", 32'(dv_cnt), 32'd1);

        // Reset asserted two bits into a frame of 0x4F
        @(negedge CLK);
        RX = 1'b0;
        repeat (BIT_CLK) @(negedge CLK);
        RX = 1'b1;
        repeat (2 * BIT_CLK) @(negedge CLK);
        chk("busy mid-frame", 32'(rx_busy), 32'h1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("midreset rec_data", 32'(rec_data), 32'h00);
        chk("midreset rx_busy", 32'(rx_busy), 32'h0);
        chk("midreset overrun", 32'(overrun), 32'h0);
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        repeat (1200) @(negedge CLK);
        chk("no partial byte", 32'(dv_cnt), 32'd1);
        chk("no partial ferr", 32'(fe_cnt), 32'd0);
        send_frame(8'h53, 1'b1);
        chk("post-reset byte", 32'(rec_data), 32'h53);
        chk("post-reset overrun", 32'(overrun), 32'h0);
        pulse_clr();
        chk("clear rec_data", 32'(rec_data), 32'h00);

        // Back-to-back command bytes, acknowledged after each strobe
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_frame(cmd[i], 1'b1);
            chk("cmd byte", 32'(last_byte), 32'(cmd[i]));
            chk("cmd latency 1522+-1", 32'((last_lat >= 1521) && (last_lat <= 1523)), 32'h1);
        end
        auto_en = 1'b0;
        repeat (3) @(negedge CLK);
        chk("cmd dv count", 32'(dv_cnt), 32'd7);
        chk("cmd overrun", 32'(overrun), 32'h0);
        chk("cmd cleared", 32'(rec_data), 32'h00);

        // Start-bit glitch: 40 clocks low
        dv0  = dv_cnt;
        fe0  = fe_cnt;
        rise = -1;
        fall = -1;
        @(negedge CLK);
        RX = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (i == 40) RX = 1'b1;
            if (rx_busy === 1'b1 && rise < 0) rise = i;
            if (rx_busy === 1'b0 && rise >= 0 && fall < 0) fall = i;
        end
        chk("glitch busy rose", 32'(rise >= 0), 32'h1);
        chk("glitch busy fell <=82", 32'((fall >= 0) && (fall - rise <= 82)), 32'h1);
        chk("glitch no dv", 32'(dv_cnt), 32'(dv0));
        chk("glitch no ferr", 32'(fe_cnt), 32'(fe0));

        // Framing error with held-low line
        send_frame(8'h41, 1'b1);
        chk("pre-ferr byte", 32'(rec_data), 32'h41);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h4F, 1'b0);
        repeat (BIT_CLK) @(negedge CLK);
        RX = 1'b1;
        repeat (300) @(negedge CLK);
        chk("ferr one pulse", 32'(fe_cnt), 32'(fe0 + 1));
        chk("ferr no dv", 32'(dv_cnt), 32'(dv0));
        chk("ferr rec_data held", 32'(rec_data), 32'h41);
        chk("ferr busy idle", 32'(rx_busy), 32'h0);
        send_frame(8'h50, 1'b1);
        chk("after ferr byte", 32'(rec_data), 32'h50);
        chk("after ferr overrun", 32'(overrun), 32'h1);
        pulse_clr();

        // Overrun
        send_frame(8'h53, 1'b1);
        chk("ovr first", 32'(overrun), 32'h0);
        send_frame(8'h4F, 1'b1);
        chk("ovr set", 32'(overrun), 32'h1);
        chk("ovr rec_data", 32'(rec_data), 32'h4F);
        pulse_clr();
        chk("ovr clr rec_data", 32'(rec_data), 32'h00);
        chk("ovr clr overrun", 32'(overrun), 32'h0);

        // rec_clr on the load edge of 0x54 while 0x53 is still pending
        send_frame(8'h53, 1'b1);
        chk("sim pending", 32'(rec_data), 32'h53);
        fork
            send_frame(8'h54, 1'b1);
            begin
                @(negedge CLK);
                repeat (1522) @(negedge CLK);
                clr_manual = 1'b1;
                @(negedge CLK);
                clr_manual = 1'b0;
            end
        join
        repeat (3) @(negedge CLK);
        chk("sim rec_data", 32'(rec_data), 32'h54);
        chk("sim overrun", 32'(overrun), 32'h0);
        chk("sim latency", 32'(last_lat), 32'd1523);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
